mem_stage: RTL and testbench

LC-3b memory-access stage controller between the EX/MEM latch and the MEM/WB latch. It turns the decoded memory command of the instruction in MEM into data-cache requests, including the two-access indirect sequence (LDI/STI). It formats byte and word load data into `mdr_out`, which feeds the MEM/WB latch's MDR input, and it holds the pipeline with `stall_mem` until the access completes.

---
 rtl/mem_stage.sv | 194 +++++++++++++++++++
 tb/tb_mem_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- LC-3b memory-access stage controller (EX/MEM -> MEM/WB).
//
// Turns the decoded memory command of the instruction in MEM into data-cache
// requests, formats load data for the MEM/WB MDR input and stalls the pipe
// until the access completes.
//
// Optional feature macro: MEM_INDIRECT_EN
//   defined   : LDI/STI do a pointer fetch (IND state) then the data access.
//   undefined : mem_indirect is ignored, every access is direct.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   mem_read/mem_write     load / store in MEM (mutually exclusive)
//   mem_byte, mem_indirect byte-sized access, indirect access
//   squash_in, advance     squash of MEM instruction, EX/MEM loads new instr
//   addr_in, store_data    effective address, store source value
//   dmem_*                 data-cache request / response interface
//   mdr_out                formatted load data to MEM/WB MDR
//   stall_mem              hold upstream latches and MEM/WB
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_byte,
    input  logic        mem_indirect,
    input  logic        squash_in,
    input  logic        advance,
    input  logic [15:0] addr_in,
    input  logic [15:0] store_data,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [15:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] mdr_out,
    output logic        stall_mem
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_IND   = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] mdr_q, mdr_d;

    logic        op;
    logic        is_ind;
    logic [15:0] fin_addr;
    logic        req_rd, req_wr;
    logic        acc_final;   // current request is the data access (not pointer fetch)
    logic        final_resp;  // response completing the data access this cycle
    logic        stall;
    logic [15:0] addr;
    logic [7:0]  rbyte;
    logic [15:0] rdata_fmt;

    assign op = (mem_read | mem_write) & ~squash_in;

`ifdef MEM_INDIRECT_EN
    logic [15:0] ptr_q, ptr_d;
    logic        ind_q, ind_d;   // current sequence is indirect

    assign is_ind   = mem_indirect;
    assign fin_addr = ind_q ? ptr_q : addr_in;
`else
    logic unused_mem_indirect;

    assign unused_mem_indirect = mem_indirect;
    assign is_ind   = 1'b0;
    assign fin_addr = addr_in;
`endif

    // Byte loads pick the addressed byte and sign-extend it.
    assign rbyte     = addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
    assign rdata_fmt = mem_byte ? {{8{rbyte[7]}}, rbyte} : dmem_rdata;

    always_comb begin
        state_d    = state_q;
        mdr_d      = mdr_q;
        req_rd     = 1'b0;
        req_wr     = 1'b0;
        acc_final  = 1'b0;
        final_resp = 1'b0;
        stall      = 1'b0;
        addr       = 16'h0000;
`ifdef MEM_INDIRECT_EN
        ptr_d      = ptr_q;
        ind_d      = ind_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Squash is only honoured here; once issued, a sequence completes.
                if (op) begin
                    stall = 1'b1;
                    addr  = addr_in;
                    if (is_ind) begin
                        req_rd  = 1'b1;
                        state_d = S_IND;
`ifdef MEM_INDIRECT_EN
                        ind_d   = 1'b1;
`endif
                    end else begin
                        req_rd    = mem_read;
                        req_wr    = mem_write;
                        acc_final = 1'b1;
                        state_d   = S_FINAL;
`ifdef MEM_INDIRECT_EN
                        ind_d     = 1'b0;
`endif
                    end
                end
            end
`ifdef MEM_INDIRECT_EN
            S_IND: begin
                req_rd = 1'b1;
                addr   = addr_in;
                stall  = 1'b1;
                if (dmem_resp) begin
                    ptr_d   = dmem_rdata;
                    state_d = S_FINAL;
                end
            end
`endif
            S_FINAL: begin
                req_rd    = mem_read;
                req_wr    = mem_write;
                acc_final = 1'b1;
                addr      = fin_addr;
                stall     = ~dmem_resp;
                if (dmem_resp) begin
                    final_resp = 1'b1;
                    mdr_d      = rdata_fmt;
                    state_d    = advance ? S_IDLE : S_DONE;
`ifdef MEM_INDIRECT_EN
                    ind_d      = 1'b0;
`endif
                end
            end
            S_DONE: begin
                if (advance) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mdr_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            mdr_q   <= mdr_d;
        end
    end

`ifdef MEM_INDIRECT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 16'h0000;
            ind_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            ind_q <= ind_d;
        end
    end
`endif

    // Outputs are gated by reset_n so an in-flight request drops immediately
    // (IDLE would otherwise re-issue combinationally while reset is held).
    always_comb begin
        dmem_read        = reset_n & req_rd;
        dmem_write       = reset_n & req_wr;
        stall_mem        = reset_n & stall;
        dmem_address     = reset_n ? addr : 16'h0000;
        dmem_wdata       = 16'h0000;
        dmem_byte_enable = 2'b00;
        if (reset_n && (req_rd || req_wr)) begin
            dmem_byte_enable = 2'b11;
            if (acc_final) begin
                dmem_wdata = mem_byte ? {store_data[7:0], store_data[7:0]} : store_data;
                if (mem_byte) dmem_byte_enable = addr[0] ? 2'b10 : 2'b01;
            end
        end
        // Bypass lets MEM/WB capture load data in the response cycle itself.
        mdr_out = final_resp ? rdata_fmt : mdr_q;
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// Transaction-level reference: each instruction is a list of cache accesses
// (pointer fetch when indirect, then the data access) with chosen latencies;
// expected outputs per cycle follow from that list and the formatting rules.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, mem_byte = 1'b0, mem_indirect = 1'b0;
    logic        squash_in = 1'b0, advance = 1'b0;
    logic [15:0] addr_in = 16'h0, store_data = 16'h0, dmem_rdata = 16'h0;
    logic        dmem_resp = 1'b0;
    logic [15:0] dmem_address, dmem_wdata, mdr_out;
    logic        dmem_read, dmem_write, stall_mem;
    logic [1:0]  dmem_byte_enable;

`ifdef MEM_INDIRECT_EN
    localparam bit IND_EN = 1'b1;
`else
    localparam bit IND_EN = 1'b0;
`endif

    mem_stage dut (
        .clk(clk), .reset_n(reset_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte(mem_byte),
        .mem_indirect(mem_indirect), .squash_in(squash_in), .advance(advance),
        .addr_in(addr_in), .store_data(store_data),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
        .mdr_out(mdr_out), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] last_mdr = 16'h0;
    bit          mdr_known = 1'b1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Load-data rule: word passes through, byte is sign-extended addressed byte.
    function automatic logic [15:0] fmt(input logic [15:0] d, input bit byt, input bit hi);
        logic [7:0] b;
        if (!byt) return d;
        b = hi ? d[15:8] : d[7:0];
        return 16'($signed(b));
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; squash_in = 1'b0; advance = 1'b0;
        dmem_resp = 1'($urandom_range(0, 1)); dmem_rdata = 16'($urandom);
        #1;
        check("idle_rd", dmem_read, 1'b0);
        check("idle_wr", dmem_write, 1'b0);
        check("idle_stall", stall_mem, 1'b0);
        if (mdr_known) check("idle_mdr", mdr_out, last_mdr);
    endtask

    // One instruction. lat = cycles the request is seen before its response
    // (response arrives in request cycle lat+1). done_cyc = cycles spent in
    // DONE before advance (0: advance coincides with final response).
    task automatic txn(input bit rd, input bit byt, input bit ind, input bit sq,
                       input logic [15:0] a, input logic [15:0] sd,
                       input logic [15:0] ptr, input logic [15:0] data,
                       input int lat0, input int lat1, input int done_cyc);
        bit          ie, first, r;
        logic [15:0] fa, exp_mdr, exp_wd;
        logic [1:0]  exp_be;
        ie      = ind & IND_EN;
        fa      = ie ? ptr : a;
        exp_mdr = fmt(data, byt, fa[0]);
        exp_wd  = byt ? {sd[7:0], sd[7:0]} : sd;
        exp_be  = byt ? (fa[0] ? 2'b10 : 2'b01) : 2'b11;
        first   = 1'b1;

        @(negedge clk);
        mem_read = rd; mem_write = !rd; mem_byte = byt; mem_indirect = ind;
        squash_in = sq; addr_in = a; store_data = sd;
        dmem_resp = 1'b0; advance = 1'b0;

        if (sq) begin
            advance = 1'b1;
            #1;
            check("sq_rd", dmem_read, 1'b0);
            check("sq_wr", dmem_write, 1'b0);
            check("sq_stall", stall_mem, 1'b0);
            return;
        end

        if (ie) begin
            for (int c = 1; c <= lat0 + 1; c++) begin
                if (!first) @(negedge clk);
                first = 1'b0;
                r = (c == lat0 + 1);
                dmem_resp = r; dmem_rdata = r ? ptr : 16'($urandom); advance = 1'b0;
                #1;
                check("ptr_rd", dmem_read, 1'b1);
                check("ptr_wr", dmem_write, 1'b0);
                check("ptr_addr", dmem_address, a);
                check("ptr_stall", stall_mem, 1'b1);
            end
        end

        for (int c = 1; c <= lat1 + 1; c++) begin
            if (!first) @(negedge clk);
            first = 1'b0;
            r = (c == lat1 + 1);
            dmem_resp = r; dmem_rdata = r ? data : 16'($urandom);
            advance = r && (done_cyc == 0);
            #1;
            check("fin_rd", dmem_read, rd);
            check("fin_wr", dmem_write, !rd);
            check("fin_addr", dmem_address, fa);
            check("fin_stall", stall_mem, !r);
            if (!rd) begin
                check("fin_wdata", dmem_wdata, exp_wd);
                check("fin_be", dmem_byte_enable, exp_be);
            end
            if (r && rd) check("fin_mdr", mdr_out, exp_mdr);
        end

        for (int d = 1; d <= done_cyc; d++) begin
            @(negedge clk);
            dmem_resp = 1'($urandom_range(0, 1)); dmem_rdata = 16'($urandom);
            advance = (d == done_cyc);
            #1;
            check("done_rd", dmem_read, 1'b0);
            check("done_wr", dmem_write, 1'b0);
            check("done_stall", stall_mem, 1'b0);
            if (rd) check("done_mdr", mdr_out, exp_mdr);
        end

        last_mdr  = exp_mdr;
        mdr_known = rd;
    endtask

    initial begin
        // Reset state, with a load presented so IDLE would otherwise issue.
        reset_n = 1'b0; mem_read = 1'b1; addr_in = 16'h3000; store_data = 16'hFFFF;
        #2;
        check("rst_rd", dmem_read, 1'b0);
        check("rst_wr", dmem_write, 1'b0);
        check("rst_stall", stall_mem, 1'b0);
        check("rst_mdr", mdr_out, 16'h0000);
        check("rst_addr", dmem_address, 16'h0000);
        check("rst_wdata", dmem_wdata, 16'h0000);
        check("rst_be", dmem_byte_enable, 2'b00);
        @(negedge clk);
        mem_read = 1'b0;
        reset_n = 1'b1;
        last_mdr = 16'h0; mdr_known = 1'b1;
        idle_cycle();

        // Directed cases
        txn(1, 0, 0, 0, 16'h3000, 16'h0, 16'h0, 16'hBEEF, 1, 3, 0);
        idle_cycle();
        check("ldr_mdr_const", mdr_out, 16'hBEEF);
        txn(1, 1, 0, 0, 16'h3001, 16'h0, 16'h0, 16'h8012, 1, 2, 0);
        idle_cycle();
        check("ldb_hi_const", mdr_out, 16'hFF80);
        txn(1, 1, 0, 0, 16'h3000, 16'h0, 16'h0, 16'h8012, 1, 1, 0);
        idle_cycle();
        check("ldb_lo_const", mdr_out, 16'h0012);
        txn(0, 1, 0, 0, 16'h4001, 16'h12AB, 16'h0, 16'h0, 1, 3, 0);
`ifdef MEM_INDIRECT_EN
        txn(1, 0, 1, 0, 16'h5000, 16'h0, 16'h6000, 16'h1234, 2, 2, 0);
        idle_cycle();
        check("ldi_mdr_const", mdr_out, 16'h1234);
`endif
        txn(0, 0, 0, 1, 16'h4000, 16'h5555, 16'h0, 16'h0, 1, 1, 0);
        txn(1, 0, 0, 0, 16'h3002, 16'h0, 16'h0, 16'hA5A5, 1, 2, 3);
        idle_cycle();

        // Reset asserted during FINAL
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; mem_byte = 1'b0; mem_indirect = 1'b0;
        squash_in = 1'b0; addr_in = 16'h3000; dmem_resp = 1'b0; advance = 1'b0;
        #1;
        check("mr_issue", dmem_read, 1'b1);
        @(negedge clk);
        #1;
        check("mr_final", dmem_read, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mr_rd", dmem_read, 1'b0);
        check("mr_stall", stall_mem, 1'b0);
        check("mr_mdr", mdr_out, 16'h0000);
        check("mr_addr", dmem_address, 16'h0000);
        @(negedge clk);
        mem_read = 1'b0;
        reset_n = 1'b1;
        last_mdr = 16'h0; mdr_known = 1'b1;
        idle_cycle();

        // Randomized instructions
        for (int i = 0; i < 120; i++) begin
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(1, 4), $urandom_range(1, 4),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
